// File: rtl/trap_sequencer.sv
// Trap/mret sequencer: owns the CSR port, stalls the pipeline while it runs the
// mepc/mcause/mtval/mstatus read-modify-write, then redirects fetch for one cycle.
module trap_sequencer #(
    parameter int CSR_ADDR_W = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ecall,
    input  logic                  ebreak,
    input  logic                  ld_misaligned,
    input  logic                  st_misaligned,
    input  logic                  irq_ext,
    input  logic                  mret,
    input  logic [31:0]           pc,
    input  logic [31:0]           tval,
    input  logic [CSR_ADDR_W-1:0] pipe_csr_addr,
    input  logic [31:0]           pipe_csr_wdata,
    input  logic                  pipe_csr_we,
    input  logic                  pipe_csr_re,
    output logic                  pipe_csr_gnt,
    output logic [CSR_ADDR_W-1:0] csr_addr,
    output logic [31:0]           csr_wdata,
    output logic                  csr_we,
    output logic                  csr_re,
    input  logic [31:0]           csr_rdata,
    output logic                  stall,
    output logic                  redirect_valid,
    output logic [31:0]           redirect_pc
);
    localparam logic [CSR_ADDR_W-1:0] A_MSTATUS = CSR_ADDR_W'(12'h300);
    localparam logic [CSR_ADDR_W-1:0] A_MTVEC   = CSR_ADDR_W'(12'h305);
    localparam logic [CSR_ADDR_W-1:0] A_MEPC    = CSR_ADDR_W'(12'h341);
    localparam logic [CSR_ADDR_W-1:0] A_MCAUSE  = CSR_ADDR_W'(12'h342);
    localparam logic [CSR_ADDR_W-1:0] A_MTVAL   = CSR_ADDR_W'(12'h343);

    typedef enum logic [3:0] {
        IDLE, T_RD_MTVEC, T_RD_MSTATUS, T_WR_MEPC, T_WR_MCAUSE, T_WR_MTVAL,
        T_WR_MSTATUS, M_RD_MEPC, M_RD_MSTATUS, M_WR_MSTATUS, REDIRECT
    } state_t;

    state_t      r_state, w_next;
    logic        r_irq_masked, r_is_irq;
    logic [31:0] r_pc, r_tval, r_cause, r_vec, r_mstatus, r_redirect_pc;
    logic        w_sync_exc, w_trap_req, w_accept_trap, w_accept_mret, w_abort, w_pipe_mstatus_wr;
    logic [31:0] w_cause, w_trap_target, w_target;

    function automatic logic [31:0] f_trap_mstatus(input logic [31:0] old);
        logic [31:0] v;
        v        = old;
        v[7]     = old[3];
        v[3]     = 1'b0;
        v[12:11] = 2'b11;
        return v;
    endfunction

    function automatic logic [31:0] f_mret_mstatus(input logic [31:0] old);
        logic [31:0] v;
        v        = old;
        v[3]     = old[7];
        v[7]     = 1'b1;
        v[12:11] = 2'b00;
        return v;
    endfunction

    assign w_sync_exc    = ebreak | ecall | st_misaligned | ld_misaligned;
    assign w_trap_req    = w_sync_exc | (irq_ext & ~r_irq_masked);
    assign w_accept_trap = (r_state == IDLE) & w_trap_req;
    assign w_accept_mret = (r_state == IDLE) & ~w_trap_req & mret;
    assign w_pipe_mstatus_wr = pipe_csr_gnt & pipe_csr_we & (pipe_csr_addr == A_MSTATUS);

    always_comb begin
        w_cause = 32'h8000_000B;
        if (ebreak)             w_cause = 32'd3;
        else if (ecall)         w_cause = 32'd11;
        else if (st_misaligned) w_cause = 32'd6;
        else if (ld_misaligned) w_cause = 32'd4;
    end

    // Vectored mode only offsets interrupts; the sole interrupt source is cause 11.
    assign w_trap_target = {r_vec[31:2], 2'b00} + (((r_vec[1:0] == 2'b01) && r_is_irq) ? 32'd44 : 32'd0);
    assign w_target      = (r_state == M_WR_MSTATUS) ? r_vec : w_trap_target;
    assign redirect_pc   = r_redirect_pc;

    always_comb begin
        w_next         = r_state;
        pipe_csr_gnt   = 1'b0;
        csr_addr       = '0;
        csr_wdata      = '0;
        csr_we         = 1'b0;
        csr_re         = 1'b0;
        stall          = 1'b1;
        redirect_valid = 1'b0;
        w_abort        = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_accept_trap)      w_next = T_RD_MTVEC;
                else if (w_accept_mret) w_next = M_RD_MEPC;
                else begin
                    stall        = 1'b0;
                    pipe_csr_gnt = 1'b1;
                    csr_addr     = pipe_csr_addr;
                    csr_wdata    = pipe_csr_wdata;
                    csr_we       = pipe_csr_we;
                    csr_re       = pipe_csr_re;
                end
            end
            T_RD_MTVEC:   begin csr_re = 1'b1; csr_addr = A_MTVEC;   w_next = T_RD_MSTATUS; end
            T_RD_MSTATUS: begin csr_re = 1'b1; csr_addr = A_MSTATUS; w_next = T_WR_MEPC;    end
            T_WR_MEPC: begin
                // An interrupt arriving with MIE clear is parked until software re-enables it.
                if (r_is_irq && !csr_rdata[3]) begin
                    w_abort = 1'b1;
                    w_next  = IDLE;
                end else begin
                    csr_we = 1'b1; csr_addr = A_MEPC; csr_wdata = r_pc; w_next = T_WR_MCAUSE;
                end
            end
            T_WR_MCAUSE:  begin csr_we = 1'b1; csr_addr = A_MCAUSE;  csr_wdata = r_cause; w_next = T_WR_MTVAL; end
            T_WR_MTVAL:   begin csr_we = 1'b1; csr_addr = A_MTVAL;   csr_wdata = r_tval;  w_next = T_WR_MSTATUS; end
            T_WR_MSTATUS: begin csr_we = 1'b1; csr_addr = A_MSTATUS; csr_wdata = f_trap_mstatus(r_mstatus); w_next = REDIRECT; end
            M_RD_MEPC:    begin csr_re = 1'b1; csr_addr = A_MEPC;    w_next = M_RD_MSTATUS; end
            M_RD_MSTATUS: begin csr_re = 1'b1; csr_addr = A_MSTATUS; w_next = M_WR_MSTATUS; end
            M_WR_MSTATUS: begin csr_we = 1'b1; csr_addr = A_MSTATUS; csr_wdata = f_mret_mstatus(csr_rdata); w_next = REDIRECT; end
            REDIRECT:     begin redirect_valid = 1'b1; w_next = IDLE; end
            default:      w_next = IDLE;
        endcase
        if (rst) begin
            w_next         = IDLE;
            pipe_csr_gnt   = 1'b0;
            csr_addr       = '0;
            csr_wdata      = '0;
            csr_we         = 1'b0;
            csr_re         = 1'b0;
            stall          = 1'b0;
            redirect_valid = 1'b0;
            w_abort        = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_irq_masked  <= 1'b0;
            r_redirect_pc <= '0;
        end else begin
            r_state      <= w_next;
            r_irq_masked <= (r_irq_masked | w_abort) & irq_ext & ~w_pipe_mstatus_wr;
            if (w_next == REDIRECT) r_redirect_pc <= w_target;
        end
    end

    // Event context and CSR read captures
    always_ff @(posedge clk) begin
        if (w_accept_trap) begin
            r_pc     <= pc;
            r_cause  <= w_cause;
            r_is_irq <= ~w_sync_exc;
            r_tval   <= (~(ebreak | ecall) & (st_misaligned | ld_misaligned)) ? tval : 32'd0;
        end
        if (r_state == T_RD_MSTATUS || r_state == M_RD_MSTATUS) r_vec <= csr_rdata;
        if (r_state == T_WR_MEPC) r_mstatus <= csr_rdata;
    end
endmodule

// File: tb/tb_trap_sequencer.sv
// Bench for trap_sequencer: behavioural CSR-unit + schedule model, directed scenarios, random traffic.
module tb_trap_sequencer;
    logic        clk, rst;
    logic        ecall, ebreak, ld_misaligned, st_misaligned, irq_ext, mret;
    logic [31:0] pc, tval;
    logic [11:0] pipe_csr_addr;
    logic [31:0] pipe_csr_wdata;
    logic        pipe_csr_we, pipe_csr_re, pipe_csr_gnt;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata, csr_rdata;
    logic        csr_we, csr_re, stall, redirect_valid;
    logic [31:0] redirect_pc;

    trap_sequencer #(.CSR_ADDR_W(12)) dut (
        .clk(clk), .rst(rst), .ecall(ecall), .ebreak(ebreak),
        .ld_misaligned(ld_misaligned), .st_misaligned(st_misaligned),
        .irq_ext(irq_ext), .mret(mret), .pc(pc), .tval(tval),
        .pipe_csr_addr(pipe_csr_addr), .pipe_csr_wdata(pipe_csr_wdata),
        .pipe_csr_we(pipe_csr_we), .pipe_csr_re(pipe_csr_re), .pipe_csr_gnt(pipe_csr_gnt),
        .csr_addr(csr_addr), .csr_wdata(csr_wdata), .csr_we(csr_we), .csr_re(csr_re),
        .csr_rdata(csr_rdata), .stall(stall), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    // CSR unit stand-in: registered read, write on the edge.
    logic [31:0] csr_mem [0:4095];
    always @(posedge clk) begin
        if (csr_re) csr_rdata <= csr_mem[csr_addr];
        if (csr_we) csr_mem[csr_addr] <= csr_wdata;
    end

    // Reference model: on acceptance the whole port schedule is planned from the model's CSR image.
    typedef struct packed {
        logic [11:0] addr;
        logic [31:0] wdata;
        logic        we, re, redir, mask;
        logic [31:0] tgt;
    } slot_t;

    function automatic slot_t mk(input logic [11:0] a, input logic [31:0] d, input logic we, input logic re,
                                 input logic rd, input logic mk_mask, input logic [31:0] t);
        slot_t s;
        s.addr = a; s.wdata = d; s.we = we; s.re = re; s.redir = rd; s.mask = mk_mask; s.tgt = t;
        return s;
    endfunction

    slot_t       q[$];
    slot_t       s;
    logic [31:0] m_csr [0:4095];
    logic        m_masked, m_irq;
    logic [31:0] m_rpc, m_cause, m_tv, m_mt, m_ms, m_new;
    logic        e_stall, e_gnt, e_we, e_re, e_rv, cmp_aw;
    logic [11:0] e_addr;
    logic [31:0] e_wd;

    always @(negedge clk) begin
        if (rst) begin
            chk("rst_stall", 32'(stall), 32'd0);
            chk("rst_gnt", 32'(pipe_csr_gnt), 32'd0);
            chk("rst_we", 32'(csr_we), 32'd0);
            chk("rst_re", 32'(csr_re), 32'd0);
            chk("rst_addr", 32'(csr_addr), 32'd0);
            chk("rst_wdata", csr_wdata, 32'd0);
            chk("rst_redirect_valid", 32'(redirect_valid), 32'd0);
            q.delete();
            m_masked = 1'b0;
            m_rpc    = 32'd0;
        end else begin
            e_gnt = 1'b0; e_stall = 1'b1; e_we = 1'b0; e_re = 1'b0; e_rv = 1'b0;
            e_addr = '0; e_wd = '0; cmp_aw = 1'b0;
            if (q.size() != 0) begin
                s = q.pop_front();
                e_we = s.we; e_re = s.re; e_addr = s.addr; e_wd = s.wdata; e_rv = s.redir;
                cmp_aw = s.we | s.re;
                if (s.redir) m_rpc = s.tgt;
                if (s.we) m_csr[s.addr] = s.wdata;
                if (s.mask) m_masked = 1'b1;
            end else if (ebreak || ecall || st_misaligned || ld_misaligned || (irq_ext && !m_masked)) begin
                m_irq = !(ebreak || ecall || st_misaligned || ld_misaligned);
                if (ebreak)             m_cause = 32'd3;
                else if (ecall)         m_cause = 32'd11;
                else if (st_misaligned) m_cause = 32'd6;
                else if (ld_misaligned) m_cause = 32'd4;
                else                    m_cause = 32'h8000000B;
                m_tv = (!ebreak && !ecall && (st_misaligned || ld_misaligned)) ? tval : 32'd0;
                m_mt = m_csr[12'h305];
                m_ms = m_csr[12'h300];
                q.push_back(mk(12'h305, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0));
                q.push_back(mk(12'h300, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0));
                if (m_irq && !m_ms[3]) begin
                    q.push_back(mk(12'h000, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0));
                end else begin
                    m_new = m_ms; m_new[7] = m_ms[3]; m_new[3] = 1'b0; m_new[12:11] = 2'b11;
                    q.push_back(mk(12'h341, pc, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0));
                    q.push_back(mk(12'h342, m_cause, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0));
                    q.push_back(mk(12'h343, m_tv, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0));
                    q.push_back(mk(12'h300, m_new, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0));
                    q.push_back(mk(12'h000, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0,
                                   (m_mt & 32'hFFFF_FFFC) + ((m_mt[1:0] == 2'b01 && m_irq) ? 32'd44 : 32'd0)));
                end
            end else if (mret) begin
                m_ms = m_csr[12'h300];
                m_new = m_ms; m_new[3] = m_ms[7]; m_new[7] = 1'b1; m_new[12:11] = 2'b00;
                q.push_back(mk(12'h341, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0));
                q.push_back(mk(12'h300, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0));
                q.push_back(mk(12'h300, m_new, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0));
                q.push_back(mk(12'h000, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, m_csr[12'h341]));
            end else begin
                e_gnt = 1'b1; e_stall = 1'b0; cmp_aw = 1'b1;
                e_we = pipe_csr_we; e_re = pipe_csr_re; e_addr = pipe_csr_addr; e_wd = pipe_csr_wdata;
                if (pipe_csr_we) m_csr[pipe_csr_addr] = pipe_csr_wdata;
                if (pipe_csr_we && pipe_csr_addr == 12'h300) m_masked = 1'b0;
            end
            if (!irq_ext) m_masked = 1'b0;
            chk("stall", 32'(stall), 32'(e_stall));
            chk("pipe_csr_gnt", 32'(pipe_csr_gnt), 32'(e_gnt));
            chk("csr_we", 32'(csr_we), 32'(e_we));
            chk("csr_re", 32'(csr_re), 32'(e_re));
            chk("redirect_valid", 32'(redirect_valid), 32'(e_rv));
            chk("redirect_pc", redirect_pc, m_rpc);
            if (cmp_aw) begin
                chk("csr_addr", 32'(csr_addr), 32'(e_addr));
                chk("csr_wdata", csr_wdata, e_wd);
            end
        end
    end

    // Directed-scenario observation, indexed by cycle relative to the event.
    logic        obs_stall [0:15];
    logic        obs_rv    [0:15];
    logic        obs_gnt   [0:15];
    logic        obs_we    [0:15];
    logic [31:0] obs_rpc   [0:15];
    logic        last_gnt;
    logic [11:0] addrs [0:5];
    int          rv_count;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic observe(input int start, input int n);
        for (int c = start; c < start + n; c++) begin
            #1;
            obs_stall[c] = stall; obs_rv[c] = redirect_valid; obs_gnt[c] = pipe_csr_gnt;
            obs_we[c] = csr_we; obs_rpc[c] = redirect_pc;
            tick();
            ecall = 1'b0; ebreak = 1'b0; ld_misaligned = 1'b0; st_misaligned = 1'b0; mret = 1'b0;
        end
    endtask

    task automatic csr_set(input logic [11:0] a, input logic [31:0] v);
        pipe_csr_we = 1'b1; pipe_csr_addr = a; pipe_csr_wdata = v;
        #1;
        last_gnt = pipe_csr_gnt;
        tick();
        pipe_csr_we = 1'b0;
    endtask

    initial begin
        rst = 1'b1; ecall = 1'b0; ebreak = 1'b0; ld_misaligned = 1'b0; st_misaligned = 1'b0;
        irq_ext = 1'b0; mret = 1'b0; pc = '0; tval = '0;
        pipe_csr_addr = '0; pipe_csr_wdata = '0; pipe_csr_we = 1'b0; pipe_csr_re = 1'b0;
        addrs[0] = 12'h300; addrs[1] = 12'h305; addrs[2] = 12'h341;
        addrs[3] = 12'h342; addrs[4] = 12'h343; addrs[5] = 12'h344;
        repeat (3) tick();
        rst = 1'b0;
        #1;
        chk("reset_stall", 32'(stall), 32'd0);
        chk("reset_redirect_pc", redirect_pc, 32'd0);

        // ecall
        csr_set(12'h305, 32'h100); csr_set(12'h300, 32'h8); csr_set(12'h343, 32'h55);
        ecall = 1'b1; pc = 32'h80;
        observe(0, 10);
        rv_count = 0;
        for (int c = 0; c < 10; c++) rv_count += int'(obs_rv[c]);
        chk("ecall_redirect_c7", 32'(obs_rv[7]), 32'd1);
        chk("ecall_redirect_count", 32'(rv_count), 32'd1);
        chk("ecall_redirect_pc", obs_rpc[7], 32'h100);
        chk("ecall_redirect_pc_hold", obs_rpc[9], 32'h100);
        chk("ecall_stall_c0", 32'(obs_stall[0]), 32'd1);
        chk("ecall_stall_c8", 32'(obs_stall[8]), 32'd0);
        chk("ecall_mepc", csr_mem[12'h341], 32'h80);
        chk("ecall_mcause", csr_mem[12'h342], 32'd11);
        chk("ecall_mtval", csr_mem[12'h343], 32'd0);
        chk("ecall_mstatus", csr_mem[12'h300], 32'h1880);

        // vectored interrupt
        csr_set(12'h305, 32'h201); csr_set(12'h300, 32'h8);
        irq_ext = 1'b1; pc = 32'h444;
        observe(0, 1);
        irq_ext = 1'b0;
        observe(1, 9);
        chk("virq_redirect_c7", 32'(obs_rv[7]), 32'd1);
        chk("virq_redirect_pc", obs_rpc[7], 32'h22C);
        chk("virq_mcause", csr_mem[12'h342], 32'h8000000B);
        chk("virq_mtval", csr_mem[12'h343], 32'd0);

        // masked interrupt, then re-enabled through a pipeline mstatus write
        csr_set(12'h300, 32'h0); csr_set(12'h341, 32'h12345678);
        irq_ext = 1'b1;
        observe(0, 12);
        rv_count = 0;
        for (int c = 0; c < 12; c++) rv_count += int'(obs_rv[c]);
        chk("mirq_stall_c0", 32'(obs_stall[0]), 32'd1);
        chk("mirq_stall_c3", 32'(obs_stall[3]), 32'd1);
        chk("mirq_stall_c4", 32'(obs_stall[4]), 32'd0);
        chk("mirq_no_retrigger", 32'(obs_stall[11]), 32'd0);
        chk("mirq_no_redirect", 32'(rv_count), 32'd0);
        chk("mirq_mepc_kept", csr_mem[12'h341], 32'h12345678);
        csr_set(12'h300, 32'h8);
        chk("mirq_gnt_on_enable", 32'(last_gnt), 32'd1);
        observe(0, 1);
        irq_ext = 1'b0;
        observe(1, 9);
        chk("mirq_retaken_stall", 32'(obs_stall[0]), 32'd1);
        chk("mirq_retaken_redirect", 32'(obs_rv[7]), 32'd1);
        chk("mirq_retaken_mcause", csr_mem[12'h342], 32'h8000000B);

        // st_misaligned together with irq_ext
        csr_set(12'h305, 32'h100); csr_set(12'h300, 32'h8);
        st_misaligned = 1'b1; tval = 32'h1003; irq_ext = 1'b1; pc = 32'h90;
        observe(0, 9);
        irq_ext = 1'b0;
        observe(9, 6);
        chk("st_mcause", csr_mem[12'h342], 32'd6);
        chk("st_mtval", csr_mem[12'h343], 32'h1003);
        chk("st_redirect_pc", obs_rpc[7], 32'h100);
        chk("st_irq_taken_c8", 32'(obs_stall[8]), 32'd1);
        chk("st_irq_done_c12", 32'(obs_stall[12]), 32'd0);

        // mret
        csr_set(12'h341, 32'h84); csr_set(12'h300, 32'h1880);
        mret = 1'b1;
        observe(0, 7);
        chk("mret_redirect_c4", 32'(obs_rv[4]), 32'd1);
        chk("mret_redirect_pc", obs_rpc[4], 32'h84);
        chk("mret_stall_c5", 32'(obs_stall[5]), 32'd0);
        chk("mret_mstatus", csr_mem[12'h300], 32'h88);

        // pipeline read colliding with ebreak
        ebreak = 1'b1; pc = 32'h100; pipe_csr_re = 1'b1; pipe_csr_addr = 12'h305;
        observe(0, 10);
        pipe_csr_re = 1'b0;
        chk("arb_gnt_c0", 32'(obs_gnt[0]), 32'd0);
        chk("arb_gnt_c7", 32'(obs_gnt[7]), 32'd0);
        chk("arb_gnt_c8", 32'(obs_gnt[8]), 32'd1);
        chk("arb_mcause", csr_mem[12'h342], 32'd3);

        // reset in the middle of the trap sequence
        csr_set(12'h342, 32'hAAAA); csr_set(12'h343, 32'hBBBB); csr_set(12'h300, 32'h8);
        ecall = 1'b1; pc = 32'h70;
        observe(0, 4);
        rst = 1'b1;
        observe(4, 1);
        rst = 1'b0;
        observe(5, 2);
        chk("rst_mid_no_write", 32'(obs_we[4]), 32'd0);
        chk("rst_mid_stall", 32'(obs_stall[5]), 32'd0);
        chk("rst_mid_mcause", csr_mem[12'h342], 32'hAAAA);
        chk("rst_mid_mtval", csr_mem[12'h343], 32'hBBBB);
        chk("rst_mid_mstatus", csr_mem[12'h300], 32'h8);

        // random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            ebreak        = ($urandom_range(0, 39) == 0);
            ecall         = ($urandom_range(0, 39) == 0);
            st_misaligned = ($urandom_range(0, 39) == 0);
            ld_misaligned = ($urandom_range(0, 39) == 0);
            mret          = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 24) == 0) irq_ext = ~irq_ext;
            pc             = $urandom;
            tval           = $urandom;
            pipe_csr_addr  = addrs[$urandom_range(0, 5)];
            pipe_csr_wdata = $urandom;
            pipe_csr_we    = ($urandom_range(0, 3) == 0);
            pipe_csr_re    = ($urandom_range(0, 1) == 1);
            rst            = ($urandom_range(0, 299) == 0);
            tick();
        end
        ebreak = 1'b0; ecall = 1'b0; st_misaligned = 1'b0; ld_misaligned = 1'b0; mret = 1'b0;
        irq_ext = 1'b0; pipe_csr_we = 1'b0; pipe_csr_re = 1'b0; rst = 1'b0;
        repeat (15) tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/trap_sequencer.md
# trap_sequencer

Trap and return sequencer for the machine-mode CSR file. It owns the single CSR access port in front of the CSR unit and shares it with the pipeline's CSR instructions. On ecall, ebreak, misaligned load/store, external interrupt or mret it stalls the pipeline and performs the required read-modify-write CSR sequence (mepc, mcause, mtval, mstatus). It then issues a one-cycle PC redirect to the trap vector or to mepc.

## Interface
- `CSR_ADDR_W`, 12: CSR address width.
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `ecall`, `ebreak`, `ld_misaligned`, `st_misaligned` in 1 each: synchronous exception requests; single-cycle pulses.
- `irq_ext` in 1: external interrupt, level-sensitive.
- `mret` in 1: return request; single-cycle pulse.
- `pc` in 32: PC of the faulting instruction, valid with the request.
- `tval` in 32: faulting address, valid with the misaligned requests.
- `pipe_csr_addr` in CSR_ADDR_W, `pipe_csr_wdata` in 32, `pipe_csr_we` in 1, `pipe_csr_re` in 1: pipeline CSR request.
- `pipe_csr_gnt` out 1: the pipeline request is forwarded this cycle.
- `csr_addr` out CSR_ADDR_W, `csr_wdata` out 32, `csr_we` out 1, `csr_re` out 1: CSR port to the CSR unit.
- `csr_rdata` in 32: read data, valid the cycle after `csr_re`.
- `stall` out 1: freezes the pipeline.
- `redirect_valid` out 1, `redirect_pc` out 32: one-cycle fetch redirect.

## Operation
- **States:** IDLE, T_RD_MTVEC, T_RD_MSTATUS, T_WR_MEPC, T_WR_MCAUSE, T_WR_MTVAL, T_WR_MSTATUS, M_RD_MEPC, M_RD_MSTATUS, M_WR_MSTATUS, REDIRECT.
- **Event selection in IDLE:**
  - Priority: ebreak > ecall > st_misaligned > ld_misaligned > irq_ext (only if `irq_masked`=0) > mret.
  - Lower-priority simultaneous events are dropped, except irq_ext, which stays pending because it is a level.
- **Latched on acceptance:** pc, tval, cause and an is_irq flag. Causes: ebreak 3, ecall 11, ld 4, st 6, irq 0x8000000B.
- **Arbitration:**
  - In IDLE with no event accepted, the pipeline signals pass through to the CSR port and `pipe_csr_gnt`=1.
  - In any other case `pipe_csr_gnt`=0 and the sequencer drives the port.
- **CSR addresses:** mstatus 0x300, mtvec 0x305, mepc 0x341, mcause 0x342, mtval 0x343.
- **Trap path:**
  - T_RD_MTVEC: read mtvec.
  - T_RD_MSTATUS: read mstatus; capture mtvec.
  - T_WR_MEPC: capture mstatus. If is_irq and mstatus[3]=0, suppress the write, set `irq_masked`, go to IDLE. Otherwise write mepc=pc.
  - T_WR_MCAUSE: write mcause=cause.
  - T_WR_MTVAL: write mtval=tval for misaligned, 0 for everything else.
  - T_WR_MSTATUS: write mstatus with [7]=old[3], [3]=0, [12:11]=2'b11, other bits unchanged.
  - REDIRECT: go to IDLE.
- **Trap target:**
  - base = {mtvec[31:2],2'b00}.
  - If mtvec[1:0]=01 and is_irq, target = base+44 (4×11). Otherwise target = base.
- **mret path:**
  - M_RD_MEPC: read mepc.
  - M_RD_MSTATUS: read mstatus; capture mepc.
  - M_WR_MSTATUS: write mstatus with [3]=old[7], [7]=1, [12:11]=00.
  - REDIRECT: target = captured mepc.
- **`irq_masked`:** cleared when irq_ext=0, or when a granted pipeline write targets 0x300.
- **Busy:** events arriving while not in IDLE are ignored.

## Timing
- **Reset:** state=IDLE, `irq_masked`=0, and these outputs are 0: `stall`, `redirect_valid`, `redirect_pc`, `csr_we`, `csr_re`, `csr_wdata`, `csr_addr`.
- **Reset mid-sequence:** state returns to IDLE on the next edge; no further CSR writes are issued.
- **`stall`:** = (state≠IDLE) OR (event accepted in IDLE). It is combinational, so it is high in the event cycle.
- **Trap latency:** event in cycle 0; states occupy cycles 1–7 in sequence; REDIRECT in cycle 7. `redirect_valid`=1 in cycle 7 only; `stall` is low from cycle 8.
- **mret latency:** REDIRECT in cycle 4.
- **Masked irq:** aborts in cycle 3; `stall` is low from cycle 4; no redirect is issued.
- **Write outputs:** `csr_we` is high for exactly one cycle per write state.
- **Read outputs:** `csr_re` is high only in the RD states.
- **Registered outputs:** `redirect_pc` is registered and holds its value after REDIRECT.

## Test plan
- **ecall:** mtvec=0x00000100, mstatus=0x00000008; ecall at pc=0x80 → writes mepc=0x80, mcause=11, mtval=0, mstatus=0x00001880; redirect to 0x100 in cycle 7.
- **Vectored irq:** irq_ext=1, mtvec=0x00000201, MIE=1 → mcause=0x8000000B; redirect_pc=0x22C.
- **Masked irq:** irq_ext=1, MIE=0 → no CSR writes; stall high cycles 0–3; no re-trigger while irq_ext held. A pipeline write of 0x8 to 0x300 → irq is retaken.
- **Simultaneous st_misaligned and irq_ext:** st_misaligned at tval=0x1003 → mcause=6, mtval=0x1003; irq is then taken after the redirect.
- **mret:** mepc=0x84, mstatus=0x1880 → mstatus=0x00000088; redirect_pc=0x84 in cycle 4.
- **Arbitration and reset:** pipeline CSR read in the same cycle as ebreak → `pipe_csr_gnt`=0 until IDLE is regained. rst in T_WR_MCAUSE → no mcause/mtval/mstatus write; stall=0 after reset.
